// File: rtl/wildcube_pkg.sv
// -----------------------------------------------------------------------------
// wildcube_pkg
// Shared types and constants for the Wild Cube VGA playfield blocks.
//   gap_state_t : motion state of a barrier gap (IDLE / RIGHT / LEFT)
//   H_ACTIVE    : visible pixels per line
//   V_ACTIVE    : visible lines per frame
//   DEF_XW/YW   : default pixel coordinate widths
// -----------------------------------------------------------------------------
package wildcube_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam int unsigned DEF_XW = 10;
    localparam int unsigned DEF_YW = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } gap_state_t;

endpackage : wildcube_pkg

// File: rtl/gap_motion_fsm.sv
// -----------------------------------------------------------------------------
// gap_motion_fsm
// Bounce controller for the gap of one barrier line. Holds the motion state,
// the gap left edge and the gap length, all updated on frame boundaries.
// Ports:
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   frame        : 1-clk pulse per frame
//   start        : leave IDLE and begin moving right
//   load         : reinitialise gap position and return to IDLE (highest priority)
//   run          : motion enable
//   gap_sel      : gap length select, length = (gap_sel+1)*GAP_UNIT
//   gap_pos      : gap left edge (registered)
//   gap_len      : gap length in pixels (registered, XW+1 bits)
//   moving_r     : registered, high while the state is RIGHT
// -----------------------------------------------------------------------------
module gap_motion_fsm
    import wildcube_pkg::*;
#(
    parameter int unsigned XW       = DEF_XW,
    parameter int unsigned X_LEFT   = 9,
    parameter int unsigned X_RIGHT  = 630,
    parameter int unsigned GAP_UNIT = 32,
    parameter int unsigned GAP_INIT = 100,
    parameter int unsigned STEP     = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame,
    input  logic          start,
    input  logic          load,
    input  logic          run,
    input  logic [2:0]    gap_sel,
    output logic [XW-1:0] gap_pos,
    output logic [XW:0]   gap_len,
    output logic          moving_r
);

    localparam int unsigned CW      = XW + 1;
    localparam int unsigned LW      = XW + 3;
    localparam int unsigned LEN_MAX = X_RIGHT - X_LEFT - 1;

    localparam logic [CW-1:0] GMIN   = CW'(X_LEFT + 1);
    localparam logic [CW-1:0] STEP_C = CW'(STEP);

    gap_state_t     state_q;
    gap_state_t     state_d;
    logic [XW-1:0]  pos_d;
    logic [CW-1:0]  len_d;
    logic           moving_r_d;

    logic [LW-1:0]  len_raw;
    logic [CW-1:0]  len_new;
    logic [CW-1:0]  gmax;
    logic [CW-1:0]  pos_ext;

    // Gap length from gap_sel, clamped to the span; right limit uses the new length.
    always_comb begin
        len_raw = (LW'(gap_sel) + LW'(1)) * LW'(GAP_UNIT);
        len_new = (len_raw > LW'(LEN_MAX)) ? CW'(LEN_MAX) : CW'(len_raw);
        gmax    = CW'(X_RIGHT) - len_new;
        pos_ext = CW'(gap_pos);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next gap position/length.
    always_comb begin
        state_d = state_q;
        pos_d   = gap_pos;
        len_d   = gap_len;

        // Length is sampled only at frame boundaries so a frame never tears.
        if (frame) begin
            len_d = len_new;
        end

        if (load) begin
            state_d = IDLE;
            pos_d   = XW'(GAP_INIT);
        end else begin
            if (frame) begin
                case (state_q)
                    IDLE: begin
                        if (pos_ext > gmax) begin
                            pos_d = XW'(gmax);
                        end
                    end
                    RIGHT: begin
                        if (pos_ext > gmax) begin
                            // Gap grew past the right limit: pin it and head back.
                            pos_d   = XW'(gmax);
                            state_d = LEFT;
                        end else if (run) begin
                            if (pos_ext + STEP_C >= gmax) begin
                                pos_d   = XW'(gmax);
                                state_d = LEFT;
                            end else begin
                                pos_d = XW'(pos_ext + STEP_C);
                            end
                        end
                    end
                    LEFT: begin
                        if (pos_ext > gmax) begin
                            pos_d   = XW'(gmax);
                            state_d = LEFT;
                        end else if (run) begin
                            if (pos_ext <= GMIN + STEP_C) begin
                                pos_d   = XW'(GMIN);
                                state_d = RIGHT;
                            end else begin
                                pos_d = XW'(pos_ext - STEP_C);
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            if ((state_q == IDLE) && start) begin
                state_d = RIGHT;
            end
        end
    end

    // Output decode, registered below so moving_r tracks the state register.
    always_comb begin
        moving_r_d = (state_d == RIGHT);
    end

    // Gap position, length and direction flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_pos  <= XW'(GAP_INIT);
            gap_len  <= CW'(GAP_UNIT);
            moving_r <= 1'b0;
        end else begin
            gap_pos  <= pos_d;
            gap_len  <= len_d;
            moving_r <= moving_r_d;
        end
    end

endmodule : gap_motion_fsm

// File: rtl/gap_line_gen.sv
// -----------------------------------------------------------------------------
// gap_line_gen
// Horizontal barrier line with a bouncing gap for the Wild Cube playfield,
// plus a per-frame player collision flag. One instance per barrier.
// Optional build macro: GAP_LINE_OUTLINE_EN adds the outline_px output.
// Ports:
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   x, y         : current pixel coordinates from the shared VGA counters
//   frame        : 1-clk pulse per frame (start of vblank)
//   start, load  : motion start / gap position reinitialise
//   run, flash   : motion+solid line enable / blink enable while frozen
//   gap_sel      : gap length select
//   player_px    : player pixel for the same x,y
//   line_px      : registered line pixel, 1 clk after x,y
//   gap_pos      : current gap left edge
//   moving_r     : high while the gap moves right
//   hit          : player overlapped the line during the previous frame
//   outline_px   : (GAP_LINE_OUTLINE_EN only) registered border pixel of the line
// -----------------------------------------------------------------------------
module gap_line_gen
    import wildcube_pkg::*;
#(
    parameter int unsigned XW       = DEF_XW,
    parameter int unsigned YW       = DEF_YW,
    parameter int unsigned Y_TOP    = 78,
    parameter int unsigned THICK    = 9,
    parameter int unsigned X_LEFT   = 9,
    parameter int unsigned X_RIGHT  = 630,
    parameter int unsigned GAP_UNIT = 32,
    parameter int unsigned GAP_INIT = 100,
    parameter int unsigned STEP     = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          frame,
    input  logic          start,
    input  logic          load,
    input  logic          run,
    input  logic          flash,
    input  logic [2:0]    gap_sel,
    input  logic          player_px,
    output logic          line_px,
    output logic [XW-1:0] gap_pos,
    output logic          moving_r,
    output logic          hit
`ifdef GAP_LINE_OUTLINE_EN
    ,
    output logic          outline_px
`endif
);

    localparam int unsigned CW    = XW + 1;
    localparam int unsigned YC    = YW + 1;
    localparam int unsigned Y_BOT = Y_TOP + THICK - 1;

    // Elaboration-time sanity check on the line placement.
    if ((Y_BOT >= V_ACTIVE) || (X_RIGHT > H_ACTIVE) || (X_LEFT + 1 >= X_RIGHT)) begin : g_bad_geom
        $error("gap_line_gen: line geometry outside the visible area");
    end

    logic [CW-1:0] gap_len;
    logic [CW-1:0] x_ext;
    logic [CW-1:0] gap_end;
    logic          in_rows;
    logic          in_cols;
    logic          in_gap;
    logic          span;
    logic          hit_acc;

    gap_motion_fsm #(
        .XW       (XW),
        .X_LEFT   (X_LEFT),
        .X_RIGHT  (X_RIGHT),
        .GAP_UNIT (GAP_UNIT),
        .GAP_INIT (GAP_INIT),
        .STEP     (STEP)
    ) u_motion (
        .clk      (clk),
        .reset_n  (reset_n),
        .frame    (frame),
        .start    (start),
        .load     (load),
        .run      (run),
        .gap_sel  (gap_sel),
        .gap_pos  (gap_pos),
        .gap_len  (gap_len),
        .moving_r (moving_r)
    );

    // Line coverage for the current pixel, gap cut out.
    always_comb begin
        x_ext   = CW'(x);
        gap_end = CW'(gap_pos) + gap_len;
        in_rows = (YC'(y) >= YC'(Y_TOP)) && (YC'(y) <= YC'(Y_BOT));
        in_cols = (x_ext > CW'(X_LEFT)) && (x_ext < CW'(X_RIGHT));
        in_gap  = (x_ext >= CW'(gap_pos)) && (x_ext < gap_end);
        span    = in_rows && in_cols && !in_gap;
    end

    // Pixel output; blinks via flash while frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_px <= 1'b0;
        end else begin
            line_px <= span && (run || flash);
        end
    end

    // Collision accumulator; an overlap on the frame clk counts toward the new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit     <= 1'b0;
            hit_acc <= 1'b0;
        end else if (frame) begin
            hit     <= hit_acc;
            hit_acc <= span && player_px;
        end else begin
            hit_acc <= hit_acc || (span && player_px);
        end
    end

`ifdef GAP_LINE_OUTLINE_EN
    logic on_edge;

    // Border of the solid part: top/bottom rows, outer ends, and both gap walls.
    always_comb begin
        on_edge = (YC'(y) == YC'(Y_TOP))
               || (YC'(y) == YC'(Y_BOT))
               || (x_ext == CW'(X_LEFT + 1))
               || (x_ext == CW'(X_RIGHT - 1))
               || (x_ext == CW'(gap_pos) - CW'(1))
               || (x_ext == gap_end);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outline_px <= 1'b0;
        end else begin
            outline_px <= span && on_edge;
        end
    end
`endif

endmodule : gap_line_gen

// File: tb/tb_gap_line_gen.sv
module tb_gap_line_gen;

    logic       clk;
    logic       reset_n;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame;
    logic       start;
    logic       load;
    logic       run;
    logic       flash;
    logic [2:0] gap_sel;
    logic       player_px;
    logic       line_px;
    logic [9:0] gap_pos;
    logic       moving_r;
    logic       hit;
`ifdef GAP_LINE_OUTLINE_EN
    logic       outline_px;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    gap_line_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x         (x),
        .y         (y),
        .frame     (frame),
        .start     (start),
        .load      (load),
        .run       (run),
        .flash     (flash),
        .gap_sel   (gap_sel),
        .player_px (player_px),
        .line_px   (line_px),
        .gap_pos   (gap_pos),
        .moving_r  (moving_r),
        .hit       (hit)
`ifdef GAP_LINE_OUTLINE_EN
        ,
        .outline_px(outline_px)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] vx;
        logic [9:0] vy;
        logic       vrun;
        logic       vflash;
        logic       exp_px;
    } vec_t;

    vec_t vecs [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick();
    endtask

    initial begin
        int n;

        vecs[0]  = '{10'd50,  10'd80, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{10'd110, 10'd80, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{10'd100, 10'd80, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{10'd99,  10'd80, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{10'd131, 10'd80, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{10'd132, 10'd80, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{10'd9,   10'd80, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{10'd10,  10'd80, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{10'd629, 10'd80, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{10'd630, 10'd80, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{10'd50,  10'd77, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{10'd50,  10'd78, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{10'd50,  10'd86, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{10'd50,  10'd87, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{10'd50,  10'd80, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{10'd50,  10'd80, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; x = '0; y = '0; frame = 1'b0; start = 1'b0; load = 1'b0;
        run = 1'b1; flash = 1'b0; gap_sel = 3'd0; player_px = 1'b0;
        tick(); tick();
        check("rst_gap_pos",  32'(gap_pos),  32'd100);
        check("rst_line_px",  32'(line_px),  32'd0);
        check("rst_moving_r", 32'(moving_r), 32'd0);
        check("rst_hit",      32'(hit),      32'd0);
        #2 reset_n = 1'b1;
        tick();

        // Span / gap / blink table at the reset gap (100..131).
        for (int i = 0; i < 16; i++) begin
            x = vecs[i].vx; y = vecs[i].vy; run = vecs[i].vrun; flash = vecs[i].vflash;
            tick();
            check($sformatf("span_vec%0d", i), 32'(line_px), 32'(vecs[i].exp_px));
        end
        check("idle_moving_r", 32'(moving_r), 32'd0);

        // Motion to the right and bounce at GMAX=598.
        run = 1'b1; flash = 1'b0; y = 10'd0; x = 10'd0;
        load = 1'b1; tick(); load = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("start_moving_r", 32'(moving_r), 32'd1);
        for (int i = 0; i < 10; i++) pulse_frame();
        check("pos_after_10", 32'(gap_pos), 32'd120);
        n = 0;
        while (moving_r == 1'b1 && n < 400) begin
            pulse_frame();
            n++;
        end
        check("frames_to_bounce", 32'(n),        32'd239);
        check("bounce_pos",       32'(gap_pos),  32'd598);
        check("bounce_moving_r",  32'(moving_r), 32'd0);
        pulse_frame();
        check("left_step_pos", 32'(gap_pos), 32'd596);

        // Frozen: position holds, line follows flash.
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flash = ~flash;
            pulse_frame();
        end
        check("frozen_pos", 32'(gap_pos), 32'd596);
        x = 10'd50; y = 10'd80; flash = 1'b1; tick();
        check("flash_on_px", 32'(line_px), 32'd1);
        flash = 1'b0; tick();
        check("flash_off_px", 32'(line_px), 32'd0);

        // Gap growth past the right limit while moving right.
        run = 1'b1; y = 10'd0;
        load = 1'b1; tick(); load = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (gap_pos != 10'd590 && n < 400) begin
            pulse_frame();
            n++;
        end
        check("frames_to_590",  32'(n),        32'd245);
        check("at590_moving_r", 32'(moving_r), 32'd1);
        gap_sel = 3'd3;
        pulse_frame();
        check("grow_clamp_pos",      32'(gap_pos),  32'd502);
        check("grow_clamp_moving_r", 32'(moving_r), 32'd0);
        x = 10'd629; y = 10'd80; tick();
        check("wide_gap_end_px", 32'(line_px), 32'd0);
        x = 10'd499; tick();
        check("wide_gap_left_px", 32'(line_px), 32'd1);

        // Collision flag, one-frame latency.
        y = 10'd0;
        pulse_frame();
        check("hit_clear", 32'(hit), 32'd0);
        x = 10'd50; y = 10'd80; player_px = 1'b1; tick();
        player_px = 1'b0; y = 10'd0; tick();
        check("hit_before_frame", 32'(hit), 32'd0);
        pulse_frame();
        check("hit_set", 32'(hit), 32'd1);
        pulse_frame();
        check("hit_drop", 32'(hit), 32'd0);
        x = 10'd9; y = 10'd80; player_px = 1'b1; tick();
        player_px = 1'b0; y = 10'd0;
        pulse_frame();
        check("hit_outside_span", 32'(hit), 32'd0);
        x = 10'd50; y = 10'd80; player_px = 1'b1; frame = 1'b1; tick();
        player_px = 1'b0; frame = 1'b0; y = 10'd0; tick();
        check("hit_frame_clk_old", 32'(hit), 32'd0);
        pulse_frame();
        check("hit_frame_clk_new", 32'(hit), 32'd1);

        // load overrides a simultaneous frame while moving left.
        check("pre_load_moving_r", 32'(moving_r), 32'd0);
        load = 1'b1; frame = 1'b1; tick();
        load = 1'b0; frame = 1'b0; tick();
        check("load_pos",      32'(gap_pos),  32'd100);
        check("load_moving_r", 32'(moving_r), 32'd0);

        // Build up activity, then async reset mid-frame.
        start = 1'b1; tick(); start = 1'b0;
        x = 10'd50; y = 10'd80; player_px = 1'b1; tick(); player_px = 1'b0;
        pulse_frame();
        check("pre_rst_hit",     32'(hit),      32'd1);
        check("pre_rst_pos",     32'(gap_pos),  32'd102);
        check("pre_rst_line_px", 32'(line_px),  32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_line_px",  32'(line_px),  32'd0);
        check("async_rst_hit",      32'(hit),      32'd0);
        check("async_rst_moving_r", 32'(moving_r), 32'd0);
        check("async_rst_gap_pos",  32'(gap_pos),  32'd100);
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gap_line_gen
